// File: rtl/mips_ctrl_pipe_if.sv
// Bus bundle for the MIPS main-control decoder and its control pipeline.
// The master side presents ID-stage fields and per-stage stall/flush; the
// slave side returns the ID hold request and the packed stage control words.
interface mips_ctrl_pipe_if #(
   parameter int STAGES = 3
);
   logic                  id_valid;
   logic [5:0]            op;
   logic [4:0]            rs;
   logic [4:0]            rt;
   logic [4:0]            rd;
   logic [STAGES-1:0]     stall;
   logic [STAGES-1:0]     flush;
   logic                  id_stall;
   logic [15*STAGES-1:0]  stage_q;

   modport master (
      output id_valid, op, rs, rt, rd, stall, flush,
      input  id_stall, stage_q
   );

   modport slave (
      input  id_valid, op, rs, rt, rd, stall, flush,
      output id_stall, stage_q
   );
endinterface

// File: rtl/mips_ctrl_pipe.sv
// Main-control decoder plus a STAGES-deep control pipeline (EX, MEM, WB, ...).
// Each stage has its own stall and flush; a load in EX whose destination is
// read by the ID instruction inserts exactly one bubble into EX.
module mips_ctrl_pipe #(
   parameter int STAGES   = 3,
   parameter int LINK_REG = 31
) (
   input logic             clk,
   input logic             rst,
   mips_ctrl_pipe_if.slave bus
);

   localparam logic [5:0] OP_R      = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [4:0] LINK      = 5'(LINK_REG);

   // Field order matches the 15-bit slice layout of stage_q.
   typedef struct packed {
      logic [4:0] wreg;
      logic       valid;
      logic       jump;
      logic       mem_to_reg;
      logic       mem_write;
      logic       jal;
      logic       bal;
      logic       branch;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
   } ctrl_t;

   logic  is_r, is_regimm, is_j, is_jal, is_cond_br, is_imm, is_lui;
   logic  is_lw, is_sw, is_beq_bne, is_link_rt;
   logic  uses_rs, uses_rt, load_use;
   logic  [STAGES-1:0] hold;
   ctrl_t dec;
   ctrl_t id_word;
   ctrl_t s0;
   ctrl_t stage_r [STAGES];

   assign is_r       = (bus.op == OP_R);
   assign is_regimm  = (bus.op == OP_REGIMM);
   assign is_j       = (bus.op == OP_J);
   assign is_jal     = (bus.op == OP_JAL);
   assign is_beq_bne = (bus.op == OP_BEQ) | (bus.op == OP_BNE);
   assign is_cond_br = is_beq_bne | (bus.op == OP_BLEZ) | (bus.op == OP_BGTZ);
   assign is_imm     = (bus.op[5:3] == 3'b001);
   assign is_lui     = (bus.op == OP_LUI);
   assign is_lw      = (bus.op == OP_LW);
   assign is_sw      = (bus.op == OP_SW);
   // BLTZAL (10000) and BGEZAL (10001) are the only linking REGIMM forms.
   assign is_link_rt = is_regimm & (bus.rt[4:1] == 4'b1000);

   assign uses_rs = ~(is_j | is_jal | is_lui);
   assign uses_rt = is_r | is_beq_bne | is_sw;

   // Decode the ID-stage fields into a raw control word and destination.
   always_comb begin
      // NOTE: default every field first so no path leaves a signal unassigned,
      // which would otherwise infer a latch.
      dec            = '0;
      dec.jump       = is_j | is_jal;
      dec.jal        = is_jal;
      dec.bal        = is_link_rt;
      dec.mem_to_reg = is_lw;
      dec.mem_write  = is_sw;
      dec.branch     = is_cond_br | is_regimm;
      dec.alusrc     = is_lw | is_sw | is_imm;
      dec.regdst     = is_r;
      if (dec.jal || dec.bal)
         dec.wreg = LINK;
      else if (dec.regdst)
         dec.wreg = bus.rd;
      else
         dec.wreg = bus.rt;
      // Writes to $0 are dropped here so downstream forwarding never sees them.
      dec.regwrite = (is_r | is_lw | is_imm | is_jal | is_link_rt) & (dec.wreg != 5'd0);
   end

   // Gate the control bits with id_valid so an ID bubble travels as a no-op.
   always_comb begin
      id_word       = dec;
      id_word.valid = bus.id_valid;
      id_word[8:0]  = dec[8:0] & {9{bus.id_valid}};
   end

   // A stalled stage freezes itself and every stage upstream of it.
   always_comb begin
      hold = '0;
      for (int i = 0; i < STAGES; i++)
         hold[i] = |(bus.stall >> i);
   end

   assign s0       = stage_r[0];
   assign load_use = bus.id_valid & s0.valid & s0.mem_to_reg & s0.regwrite &
                     ((uses_rs & (bus.rs == s0.wreg)) | (uses_rt & (bus.rt == s0.wreg)));
   assign bus.id_stall = load_use | hold[0];

   for (genvar g = 0; g < STAGES; g++) begin : g_out
      assign bus.stage_q[g*15 +: 15] = stage_r[g];
   end

   // Advance the control pipeline: reset, then flush, then hold, then load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its upstream neighbour's pre-edge value.
      if (rst) begin
         // NOTE: these are a handful of flops, not a RAM, so every stage is
         // cleared by reset and a bubble is guaranteed from the first edge.
         for (int i = 0; i < STAGES; i++)
            stage_r[i] <= '0;
      end else begin
         if (bus.flush[0])
            stage_r[0] <= '0;
         else if (!hold[0])
            stage_r[0] <= load_use ? ctrl_t'('0) : id_word;
         for (int i = 1; i < STAGES; i++) begin
            if (bus.flush[i])
               stage_r[i] <= '0;
            else if (!hold[i])
               stage_r[i] <= hold[i-1] ? ctrl_t'('0) : stage_r[i-1];
         end
      end
   end

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Self-checking bench for mips_ctrl_pipe with STAGES=3 (EX, MEM, WB).
// Table-driven decode vectors, hand-written multi-cycle sequences, and a
// WB-stage scoreboard that checks order and arrival cycle.
module tb_mips_ctrl_pipe;
   localparam int STAGES = 3;

   localparam logic [5:0] OP_R = 6'd0, OP_RI = 6'd1, OP_J = 6'd2, OP_JAL = 6'd3;
   localparam logic [5:0] OP_BEQ = 6'd4, OP_ADDI = 6'd8, OP_LUI = 6'd15;
   localparam logic [5:0] OP_LW = 6'd35, OP_SW = 6'd43, OP_BAD = 6'd63;

   // Expected words: {wreg, valid jump m2r mw jal bal branch alusrc regdst regwrite}
   localparam logic [14:0] W_LW8    = {5'd8,  10'b1010000101};
   localparam logic [14:0] W_LW0    = {5'd0,  10'b1010000100};
   localparam logic [14:0] W_ADD9   = {5'd9,  10'b1000000011};

   typedef struct {
      logic        id_valid;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [14:0] exp;
   } vec_t;

   typedef struct {
      logic [14:0] word;
      int          due;
   } sb_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   bit   sb_on = 1'b0;
   bit   sb_timed = 1'b1;
   vec_t vecs[$];
   sb_t  sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips_ctrl_pipe_if #(.STAGES(STAGES)) bus ();
   mips_ctrl_pipe #(.STAGES(STAGES), .LINK_REG(31)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [14:0] sq(input int i);
      return bus.stage_q[i*15 +: 15];
   endfunction

   function automatic logic [14:0] addi_w(input logic [4:0] rt);
      return {rt, 10'b1000000101};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
      bus.id_valid = v;
      bus.op       = op;
      bus.rs       = rs;
      bus.rt       = rt;
      bus.rd       = rd;
   endtask

   // Present the driven instruction for one cycle; record it if accepted.
   task automatic issue(input logic [14:0] exp_word, output bit stalled);
      sb_t e;
      @(negedge clk);
      stalled = bus.id_stall;
      if (!stalled && !rst && sb_on && exp_word[9]) begin
         e.word = exp_word;
         e.due  = sb_timed ? cyc + 3 : -1;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [14:0] exp);
      vec_t t;
      t.id_valid = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.exp = exp;
      vecs.push_back(t);
   endtask

   // WB-stage scoreboard: every valid word leaving stage 2 must be the next
   // expected one, on time when timing is tracked.
   always @(posedge clk) begin
      sb_t e;
      #1;
      if (sb_on && !rst && sq(2)[9]) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", {49'd0, sq(2)}, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("wb_word", {49'd0, sq(2)}, {49'd0, e.word});
            if (e.due >= 0)
               check("wb_latency", cyc, e.due);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit          st;
      logic [14:0] prev;

      add_vec(1, OP_R,   5'd1, 5'd2,  5'd5, {5'd5,  10'b1000000011}); // ADDU rd=5
      add_vec(1, OP_JAL, 5'd0, 5'd0,  5'd0, {5'd31, 10'b1100100001}); // JAL
      add_vec(1, OP_RI,  5'd2, 5'd17, 5'd0, {5'd31, 10'b1000011001}); // BGEZAL
      add_vec(1, OP_RI,  5'd2, 5'd1,  5'd0, {5'd1,  10'b1000001000}); // BGEZ
      add_vec(1, OP_BAD, 5'd0, 5'd3,  5'd0, {5'd3,  10'b1000000000}); // unknown
      add_vec(1, OP_ADDI,5'd2, 5'd9,  5'd0, {5'd9,  10'b1000000101}); // ADDI
      add_vec(1, OP_LW,  5'd4, 5'd10, 5'd0, {5'd10, 10'b1010000101}); // LW
      add_vec(1, OP_SW,  5'd4, 5'd11, 5'd0, {5'd11, 10'b1001000100}); // SW
      add_vec(1, OP_R,   5'd1, 5'd3,  5'd0, {5'd0,  10'b1000000010}); // ADDU rd=0
      add_vec(1, OP_J,   5'd0, 5'd7,  5'd0, {5'd7,  10'b1100000000}); // J
      add_vec(1, OP_BEQ, 5'd1, 5'd6,  5'd0, {5'd6,  10'b1000001000}); // BEQ
      add_vec(1, OP_LUI, 5'd0, 5'd12, 5'd0, {5'd12, 10'b1000000101}); // LUI
      add_vec(1, OP_RI,  5'd2, 5'd16, 5'd0, {5'd31, 10'b1000011001}); // BLTZAL
      add_vec(0, OP_LW,  5'd0, 5'd0,  5'd0, 15'd0);                   // ID bubble

      // Reset held two cycles with a LW presented.
      bus.stall = '0;
      bus.flush = '0;
      rst = 1'b1;
      sb_on = 1'b1;
      drive(1, OP_LW, 5'd0, 5'd8, 5'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_stage_q", {19'd0, bus.stage_q}, 64'd0);
         check("rst_id_stall", bus.id_stall, 0);
      end
      rst = 1'b0;
      issue(W_LW8, st);
      check("rst_release_stall", st, 0);
      check("rst_release_s0", sq(0), W_LW8);

      // Decode sweep: stage 0 gets the vector, stage 1 the previous one.
      prev = W_LW8;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].id_valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
         issue(vecs[i].exp, st);
         check($sformatf("vec%0d_id_stall", i), st, 0);
         check($sformatf("vec%0d_s0", i), sq(0), vecs[i].exp);
         check($sformatf("vec%0d_s1", i), sq(1), prev);
         prev = vecs[i].exp;
      end

      // Load-use: LW $8 then ADD reading $8 costs exactly one bubble.
      drive(1, OP_LW, 5'd0, 5'd8, 5'd0);
      issue(W_LW8, st);
      check("lu_lw_stall", st, 0);
      drive(1, OP_R, 5'd8, 5'd1, 5'd9);
      issue(W_ADD9, st);
      check("lu_id_stall", st, 1);
      check("lu_s0_bubble", sq(0), 15'd0);
      check("lu_s1_lw", sq(1), W_LW8);
      issue(W_ADD9, st);
      check("lu_cleared", st, 0);
      check("lu_s0_add", sq(0), W_ADD9);

      // Same sequence with LW to $0: no hazard.
      drive(1, OP_LW, 5'd0, 5'd0, 5'd0);
      issue(W_LW0, st);
      drive(1, OP_R, 5'd0, 5'd1, 5'd9);
      issue(W_ADD9, st);
      check("lu0_no_stall", st, 0);
      check("lu0_s0_add", sq(0), W_ADD9);
      check("lu0_s1_lw", sq(1), W_LW0);

      // stall[1] for two cycles in an ADDI stream.
      sb_timed = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         drive(1, OP_ADDI, 5'd0, 5'(k), 5'd0);
         issue(addi_w(5'(k)), st);
      end
      bus.stall = 3'b010;
      drive(1, OP_ADDI, 5'd0, 5'd4, 5'd0);
      for (int k = 0; k < 2; k++) begin
         issue(addi_w(5'd4), st);
         check("st_id_stall", st, 1);
         check("st_s0_frozen", sq(0), addi_w(5'd3));
         check("st_s1_frozen", sq(1), addi_w(5'd2));
         check("st_s2_bubble", sq(2), 15'd0);
      end
      bus.stall = '0;
      issue(addi_w(5'd4), st);
      check("st_resume_stall", st, 0);
      check("st_resume_s0", sq(0), addi_w(5'd4));
      check("st_resume_s2", sq(2), addi_w(5'd2));
      for (int k = 5; k <= 6; k++) begin
         drive(1, OP_ADDI, 5'd0, 5'(k), 5'd0);
         issue(addi_w(5'(k)), st);
      end
      drive(0, OP_R, 5'd0, 5'd0, 5'd0);
      repeat (4) issue(15'd0, st);
      check("sb_drained", sb_q.size(), 0);
      sb_on = 1'b0;

      // flush[0] with stall[0], then flush[2] alone.
      for (int k = 1; k <= 3; k++) begin
         drive(1, OP_ADDI, 5'd0, 5'(k), 5'd0);
         issue(addi_w(5'(k)), st);
      end
      bus.flush = 3'b001;
      bus.stall = 3'b001;
      drive(1, OP_ADDI, 5'd0, 5'd4, 5'd0);
      issue(addi_w(5'd4), st);
      check("fs_id_stall", st, 1);
      check("fs_s0_zero", sq(0), 15'd0);
      check("fs_s1_bubble", sq(1), 15'd0);
      check("fs_s2_moves", sq(2), addi_w(5'd2));
      bus.flush = '0;
      bus.stall = '0;
      issue(addi_w(5'd4), st);
      drive(1, OP_ADDI, 5'd0, 5'd5, 5'd0);
      issue(addi_w(5'd5), st);
      bus.flush = 3'b100;
      drive(1, OP_ADDI, 5'd0, 5'd6, 5'd0);
      issue(addi_w(5'd6), st);
      check("f2_s0", sq(0), addi_w(5'd6));
      check("f2_s1", sq(1), addi_w(5'd5));
      check("f2_s2_zero", sq(2), 15'd0);
      bus.flush = '0;

      // Reset pulse while stall[2] and a load-use are both active.
      drive(1, OP_LW, 5'd0, 5'd8, 5'd0);
      issue(W_LW8, st);
      drive(1, OP_R, 5'd8, 5'd1, 5'd9);
      bus.stall = 3'b100;
      #1;
      check("rp_id_stall_pre", bus.id_stall, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rp_stage_q", {19'd0, bus.stage_q}, 64'd0);
      check("rp_id_stall_stall", bus.id_stall, 1);
      bus.stall = '0;
      #1;
      check("rp_id_stall_clear", bus.id_stall, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
